// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if: request, ALU-side and result signals of the 8-bit ALU issue stage.
//   master : environment side (drives requests, alu_y, out_ready)
//   slave  : issue unit side (drives in_ready, alu_*, out_*, busy)
// Parameter TAG_W sets the width of the request/result tag.
interface alu_issue_unit_if #(
  parameter int unsigned TAG_W = 2
);
  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [3:0]       in_sel;
  logic             in_c_in;
  logic [TAG_W-1:0] in_tag;
  logic             in_use_prev;
  // ALU operand/result bus
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_sel;
  logic             alu_c_in;
  logic [7:0]       alu_y;
  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_y;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_c_in, in_tag, in_use_prev, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, alu_c_in, out_valid, out_y, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_c_in, in_tag, in_use_prev, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, alu_c_in, out_valid, out_y, out_tag, busy
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue stage in front of the 8-bit ALU.
// Requests are queued in a DEPTH-entry FIFO and issued one at a time: operands are registered
// onto alu_a/alu_b/alu_sel/alu_c_in, alu_y is captured ALU_LAT edges later and presented with
// its tag on out_valid/out_ready. Only one operation is ever in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_issue_unit_if.slave: in_* request channel, alu_* ALU bus, out_* result, busy
// Optional feature (macro ALU_FWD_EN): an entry with in_use_prev set takes operand A from the
// last accepted result instead of its stored a. Without the macro in_use_prev is ignored.
module alu_issue_unit #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned TAG_W   = 2
) (
  input logic             clk,
  input logic             rst,
  alu_issue_unit_if.slave bus
);
  localparam int unsigned     PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(ALU_LAT + 1);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);
  localparam logic [CntW-1:0] LatLoad   = CntW'(ALU_LAT);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  // Request storage
  logic [7:0]       mem_a   [DEPTH];
  logic [7:0]       mem_b   [DEPTH];
  logic [3:0]       mem_sel [DEPTH];
  logic             mem_cin [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full, push, pop;
  logic [7:0]      head_a;

  state_e           state_q, state_d;
  logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             alu_c_in_q, alu_c_in_d;
  logic [TAG_W-1:0] tag_hold_q, tag_hold_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_y_q, out_y_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [7:0]       last_q, last_d;

  assign full = (count_q == FullCount);
  assign push = bus.in_valid & ~full;
  // Pop only from IDLE, so a DONE->IDLE handshake never pops on the same edge.
  assign pop  = (state_q == StIdle) & (count_q != '0);

`ifdef ALU_FWD_EN
  logic mem_prev [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_prev[wr_ptr_q] <= bus.in_use_prev;
  end

  assign head_a = mem_prev[rd_ptr_q] ? last_q : mem_a[rd_ptr_q];
`else
  logic unused_use_prev;
  assign unused_use_prev = bus.in_use_prev;
  assign head_a          = mem_a[rd_ptr_q];
`endif

  // FIFO payload needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q]   <= bus.in_a;
      mem_b[wr_ptr_q]   <= bus.in_b;
      mem_sel[wr_ptr_q] <= bus.in_sel;
      mem_cin[wr_ptr_q] <= bus.in_c_in;
      mem_tag[wr_ptr_q] <= bus.in_tag;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_c_in_d  = alu_c_in_q;
    tag_hold_d  = tag_hold_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    last_d      = last_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          alu_a_d    = head_a;
          alu_b_d    = mem_b[rd_ptr_q];
          alu_sel_d  = mem_sel[rd_ptr_q];
          alu_c_in_d = mem_cin[rd_ptr_q];
          tag_hold_d = mem_tag[rd_ptr_q];
          wait_cnt_d = LatLoad;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == CntOne) begin
          out_y_d     = bus.alu_y;
          out_tag_d   = tag_hold_q;
          out_valid_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q - CntOne;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          last_d      = out_y_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_c_in_q  <= 1'b0;
      tag_hold_q  <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      last_q      <= '0;
    end else begin
      // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_c_in_q  <= alu_c_in_d;
      tag_hold_q  <= tag_hold_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_c_in  = alu_c_in_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.busy      = (state_q != StIdle) | (count_q != '0);
endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed scenarios plus randomized traffic, with a
// queue-based scoreboard fed at push time and drained by an independent result monitor.
module tb_alu_issue_unit;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ALU_LAT = 2;
  localparam int unsigned TAG_W   = 2;
`ifdef ALU_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]       y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_last = '0;
  logic       rand_done;

  alu_issue_unit_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_unit #(
    .DEPTH  (DEPTH),
    .ALU_LAT(ALU_LAT),
    .TAG_W  (TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour: sel[3]=0 arithmetic, sel[3]=1 logic.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel, input logic cin);
    logic [7:0] r;
    if (!sel[3]) begin
      case (sel[2:0])
        3'd0:    r = a + b + {7'd0, cin};
        3'd1:    r = a - b - {7'd0, cin};
        3'd2:    r = a + 8'd1;
        3'd3:    r = a - 8'd1;
        default: r = a + b;
      endcase
    end else begin
      case (sel[2:0])
        3'd0:    r = a & b;
        3'd1:    r = a | b;
        3'd2:    r = a ^ b;
        3'd3:    r = ~a;
        default: r = a;
      endcase
    end
    return r;
  endfunction

  // ALU stand-in with ALU_LAT-1 = 1 register stage, so an early capture sees a stale value.
  always @(posedge clk) bus.alu_y <= alu_f(bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_c_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Results complete in push order and each op finishes before the next issues, so the
  // forwarded operand is simply the previous op's result.
  task automatic model_push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            input logic cin, input logic [TAG_W-1:0] tag, input logic up);
    logic [7:0] a_eff;
    exp_t       e;
    a_eff = (Fwd && up) ? model_last : a;
    e.y   = alu_f(a_eff, b, sel, cin);
    e.tag = tag;
    model_last = e.y;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic cin, input logic [TAG_W-1:0] tag, input logic up,
                         output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sel = sel;
    bus.in_c_in = cin; bus.in_tag = tag; bus.in_use_prev = up;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    bus.in_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
    if (ok) model_push(a, b, sel, cin, tag, up);
  endtask

  task automatic wait_out_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    @(posedge clk);
    #1;
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy && !bus.out_valid;
    end
    @(posedge clk);
    #1;
    check(name, 32'(idle), 32'd1);
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got y=%02h tag=%0d, expected no result",
                 bus.out_y, bus.out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_y", 32'(bus.out_y), 32'(mon_e.y));
        check("result_tag", 32'(bus.out_tag), 32'(mon_e.tag));
      end
    end
  end

  initial begin
    int         w;
    logic [31:0] snap;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sel = '0; bus.in_c_in = 1'b0;
    bus.in_tag = '0; bus.in_use_prev = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_alu_bus", {11'd0, bus.alu_a, bus.alu_b, bus.alu_sel, bus.alu_c_in}, 32'd0);
    check("reset_out_y_tag", {22'd0, bus.out_y, bus.out_tag}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single op latency: push edge 0, ALU driven after edge 1, result after edge 3
    push_op(8'h12, 8'h34, 4'h0, 1'b0, 2'd1, 1'b0, w);
    check("lat_valid_e0", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_alu_ab_e1", {16'd0, bus.alu_a, bus.alu_b}, 32'h1234);
    @(posedge clk); #1;
    check("lat_valid_e2", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid_e3", 32'(bus.out_valid), 32'd1);
    check("lat_y_e3", 32'(bus.out_y), 32'h46);
    check("lat_tag_e3", 32'(bus.out_tag), 32'd1);
    bus.out_ready = 1'b1;
    wait_idle("lat_drain");

    // Fill: 1 in flight + DEPTH queued, then the next request is held
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_op(8'(8'h10 * i + 1), 8'(i + 3), 4'(i), 1'b0, TAG_W'(i), 1'b0, w);
    check("fill_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("fill_busy", 32'(bus.busy), 32'd1);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join_none
    push_op(8'hA5, 8'h5A, 4'hA, 1'b0, 2'd1, 1'b0, w);
    check("fill_sixth_held", 32'(w >= 3), 32'd1);
    wait_idle("fill_drain");

    // Backpressure in DONE: everything stable, no pop of the queued op
    bus.out_ready = 1'b0;
    push_op(8'h21, 8'h43, 4'h9, 1'b1, 2'd2, 1'b0, w);
    wait_out_valid("bp_valid");
    push_op(8'hF0, 8'h0F, 4'h2, 1'b0, 2'd3, 1'b0, w);
    snap = {bus.out_valid, bus.out_y, bus.out_tag, bus.alu_a, bus.alu_b, bus.alu_sel,
            bus.alu_c_in};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stable", {bus.out_valid, bus.out_y, bus.out_tag, bus.alu_a, bus.alu_b,
                          bus.alu_sel, bus.alu_c_in}, snap);
    end
    bus.out_ready = 1'b1;
    wait_idle("bp_drain");

    // Push and pop on the same edge with DEPTH-1 queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_op(8'(8'h30 + i), 8'(8'h07 * i), 4'h0, 1'b1, TAG_W'(i), 1'b0, w);
    wait_out_valid("pp_valid");
    bus.out_ready = 1'b1;
    @(posedge clk); #1;                       // handshake edge
    push_op(8'h55, 8'h11, 4'h1, 1'b0, 2'd0, 1'b0, w);   // accepted on the pop edge
    check("pp_same_edge", 32'(w), 32'd0);
    check("pp_not_full", 32'(bus.in_ready), 32'd1);
    push_op(8'h66, 8'h22, 4'hB, 1'b0, 2'd1, 1'b0, w);
    check("pp_full_after", 32'(bus.in_ready), 32'd0);
    wait_idle("pp_drain");
    check("pp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Async reset mid-WAIT with entries queued
    bus.out_ready = 1'b1;
    push_op(8'h01, 8'h02, 4'h0, 1'b0, 2'd0, 1'b0, w);
    push_op(8'h03, 8'h04, 4'h0, 1'b0, 2'd1, 1'b0, w);
    push_op(8'h05, 8'h06, 4'h0, 1'b0, 2'd2, 1'b0, w);
    rst = 1'b1;
    exp_q.delete();
    model_last = '0;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_stale_valid", 32'(bus.out_valid), 32'd0);
    check("rst_no_stale_busy", 32'(bus.busy), 32'd0);

    // Operand forwarding from the last accepted result
    push_op(8'h05, 8'h03, 4'h0, 1'b0, 2'd0, 1'b0, w);
    wait_idle("fwd_op1_drain");
    bus.out_ready = 1'b0;
    push_op(8'h40, 8'h01, 4'h0, 1'b0, 2'd1, 1'b1, w);
    wait_out_valid("fwd_op2_valid");
    check("fwd_alu_a", 32'(bus.alu_a), Fwd ? 32'h08 : 32'h40);
    check("fwd_out_y", 32'(bus.out_y), Fwd ? 32'h09 : 32'h41);
    bus.out_ready = 1'b1;
    wait_idle("fwd_drain");

    // Randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          push_op(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), TAG_W'($urandom),
                  1'($urandom), w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_idle("rand_drain");
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Upstream issue stage for the 8-bit ALU.
- Buffers operation requests (a, b, sel, c_in, tag) in a small FIFO and drives them one at a time onto the ALU operand/select inputs, holding them stable.
- Captures alu_y after the fixed ALU latency and presents the result with its tag on a valid/ready output.
- Exactly one operation in flight at a time.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, >=2.
- ALU_LAT, 2, rising edges from the edge that launches operands to the edge that captures alu_y; >=1.
- TAG_W, 2, width of the request tag carried through to the result.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  FIFO not full.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- in_sel  input  4  ALU select; bit 3 chooses logic vs arithmetic.
- in_c_in  input  1  carry in.
- in_tag  input  TAG_W  request tag.
- in_use_prev  input  1  use last result as operand A; honoured only with ALU_FWD_EN.
- alu_a  output  8  to ALU operand A.
- alu_b  output  8  to ALU operand B.
- alu_sel  output  4  to ALU select.
- alu_c_in  output  1  to ALU carry in.
- alu_y  input  8  ALU result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_y  output  8  captured result.
- out_tag  output  TAG_W  tag of the captured result.
- busy  output  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0 except in_ready=1.
  - FIFO empty, FSM to IDLE, wait counter 0, last-result register 0.
  - Reset mid-operation discards the in-flight op and all queued entries; no result is emitted.
- FIFO:
  - Push on in_valid&in_ready.
  - in_ready = !full; a push and a pop in the same cycle are both legal.
  - Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
  - When full, in_valid is ignored with no overwrite.
- FSM IDLE:
  - If FIFO not empty: pop the head, register it into alu_a/alu_b/alu_sel/alu_c_in and the tag holding register, load counter=ALU_LAT, go to WAIT.
  - The ALU outputs change only on this transition and hold stable through WAIT/DONE.
- FSM WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 1: capture alu_y into out_y, tag into out_tag, set out_valid=1, go to DONE.
- FSM DONE:
  - Hold out_valid/out_y/out_tag stable until out_ready=1.
  - On the handshake edge: out_valid=0, update the last-result register with out_y, go to IDLE.
  - No pop happens in the same cycle; back-to-back issue spacing is ALU_LAT+2 edges minimum.
- Latency: an entry pushed into an empty FIFO with the FSM in IDLE drives the ALU on edge+1 and asserts out_valid on edge+1+ALU_LAT.
- Ordering: results emerge strictly in push order.
- All arithmetic is 8-bit; no result widening or flag generation (owned by the ALU).
- busy = (state!=IDLE) | (count!=0).

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: at pop, if the entry's in_use_prev bit is 1, alu_a is driven from the last-result register instead of the stored a. The flag is stored per FIFO entry. The last-result register updates only on out handshake.
- Undefined: in_use_prev is ignored and not stored; alu_a is always the stored a.

Test Plan:
- Reset then single op: a=0x12, b=0x34, sel=arith-add, tag=1 pushed at edge 0 -> alu_a/alu_b=0x12/0x34 after edge 1; out_valid=1 after edge 3 with out_y=0x46, out_tag=1.
- Fill: push 5 ops with out_ready=0 -> in_ready=0 after the 4th queued entry (1 in flight + 4 queued); the 6th request is held; all results drain in tag order 0,1,2,3,0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_y/out_tag and alu_* stable throughout; no new pop.
- Simultaneous push/pop while FIFO full-minus-one -> occupancy unchanged, no drop or duplicate.
- Async reset asserted mid-WAIT -> out_valid=0, in_ready=1, busy=0 immediately; no stale result after release.
- ALU_FWD_EN: op1 a=0x05, b=0x03 (add) -> 0x08; op2 in_use_prev=1, b=0x01 (add) -> alu_a=0x08, out_y=0x09; with the macro undefined, out_y equals the stored a+0x01.
